// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: flag bit positions and the packed flag word.
package alu_pkg;

  localparam int unsigned FLAGS_W = 4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_P = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  // MSB first, so bit FLAG_Z is the LSB of the packed word
  typedef struct packed {
    logic v;
    logic c;
    logic p;
    logic z;
  } flags_t;

endpackage : alu_pkg

// File: rtl/flag_reg.sv
// Four-bit enable register holding the ALU condition flags.
module flag_reg
  import alu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  flags_t d,
  output flags_t q
);

  flags_t q_q;
  flags_t q_d;

  // Load all flags together on enable, otherwise hold
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Flag storage, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : flag_reg

// File: rtl/reg_file.sv
// General-purpose register file with two combinational operand ports,
// a shared tristate result bus and the ALU flags register.
module reg_file
  import alu_pkg::*;
#(
  parameter  int unsigned DATA_W     = 8,
  parameter  int unsigned NUM_REGS   = 8,
  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     operand_a,
  output logic [DATA_W-1:0]     operand_b,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic                  bus_oe,
  input  logic [REG_ADDR_W-1:0] bus_rd_addr,
  inout  wire  [DATA_W-1:0]     data_bus,
  input  logic                  flags_we,
  input  logic                  zero_flag_in,
  input  logic                  positive_flag_in,
  input  logic                  carry_flag_in,
  input  logic                  signed_overflow_in,
  output logic [FLAGS_W-1:0]    flags,
  output logic                  bus_conflict
);

  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic               bus_conflict_q;
  logic               bus_conflict_d;
  logic [FLAGS_W-1:0] flags_in_c;
  flags_t             flags_q;

  // Register write; a cycle that both drives and captures the bus writes nothing
  always_comb begin
    regs_d = regs_q;
    if (wr_en && !bus_oe) begin
      regs_d[wr_addr] = data_bus;
    end
  end

  // Register storage, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Flag a simultaneous drive and capture of the bus for the following cycle
  always_comb begin
    bus_conflict_d = wr_en && bus_oe;
  end

  // Conflict pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_conflict_q <= 1'b0;
    end else begin
      bus_conflict_q <= bus_conflict_d;
    end
  end

  // Gather the ALU condition inputs into flag-word order
  always_comb begin
    flags_in_c         = '0;
    flags_in_c[FLAG_Z] = zero_flag_in;
    flags_in_c[FLAG_P] = positive_flag_in;
    flags_in_c[FLAG_C] = carry_flag_in;
    flags_in_c[FLAG_V] = signed_overflow_in;
  end

  flag_reg u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flags_we),
    .d     (flags_t'(flags_in_c)),
    .q     (flags_q)
  );

  // Operand reads are plain muxes of current state (no write bypass)
  assign operand_a = regs_q[rd_addr_a];
  assign operand_b = regs_q[rd_addr_b];

  // Bus drive follows bus_oe combinationally; released bus floats
  assign data_bus = bus_oe ? regs_q[bus_rd_addr] : {DATA_W{1'bz}};

  assign flags        = FLAGS_W'(flags_q);
  assign bus_conflict = bus_conflict_q;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file using an expectation queue.
module tb_reg_file;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned AW     = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, bus_rd_addr;
  logic [DATA_W-1:0] operand_a, operand_b;
  logic          wr_en, bus_oe, flags_we;
  logic          zf, pf, cf, vf;
  logic [3:0]    flags;
  logic          bus_conflict;
  wire  [DATA_W-1:0] data_bus;
  logic          tb_drv;
  logic [DATA_W-1:0] tb_val;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DATA_W-1:0] model [NREGS];
  logic [7:0]        exp_q [$];
  string             tag_q [$];

  assign data_bus = tb_drv ? tb_val : 8'hzz;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(DATA_W), .NUM_REGS(NREGS)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rd_addr_a          (rd_addr_a),
    .rd_addr_b          (rd_addr_b),
    .operand_a          (operand_a),
    .operand_b          (operand_b),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .bus_oe             (bus_oe),
    .bus_rd_addr        (bus_rd_addr),
    .data_bus           (data_bus),
    .flags_we           (flags_we),
    .zero_flag_in       (zf),
    .positive_flag_in   (pf),
    .carry_flag_in      (cf),
    .signed_overflow_in (vf),
    .flags              (flags),
    .bus_conflict       (bus_conflict)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [7:0] obs);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", obs, ~obs);
    end else begin
      check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] v);
    tb_drv  = 1'b1;
    tb_val  = v;
    wr_en   = 1'b1;
    wr_addr = a;
    tick();
    wr_en  = 1'b0;
    tb_drv = 1'b0;
    model[a] = v;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; bus_rd_addr = '0;
    wr_en = 1'b1; bus_oe = 1'b0; flags_we = 1'b1;
    zf = 1'b1; pf = 1'b1; cf = 1'b1; vf = 1'b1;
    tb_drv = 1'b1; tb_val = 8'hFF;
    for (int i = 0; i < int'(NREGS); i++) model[i] = '0;

    // Reset held with a write pending: nothing may land
    repeat (3) tick();
    for (int i = 0; i < int'(NREGS); i++) begin
      rd_addr_a = AW'(i);
      #1;
      sb_push("rst_opa", 8'h00);
      sb_pop(operand_a);
    end
    sb_push("rst_flags", 8'h00);
    sb_pop({4'h0, flags});
    sb_push("rst_conflict", 8'h00);
    sb_pop({7'h0, bus_conflict});

    wr_en = 1'b0; flags_we = 1'b0; tb_drv = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < int'(NREGS); i++) begin
      rd_addr_b = AW'(i);
      #1;
      sb_push("post_rst_opb", 8'h00);
      sb_pop(operand_b);
    end

    // Write A5 to reg 3: old value visible before the edge, new value after
    rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    tb_drv = 1'b1; tb_val = 8'hA5; wr_en = 1'b1; wr_addr = 3'd3;
    #1;
    sb_push("wr_same_cycle", 8'h00);
    sb_pop(operand_a);
    tick();
    wr_en = 1'b0; tb_drv = 1'b0; model[3] = 8'hA5;
    sb_push("wr_opa", 8'hA5);
    sb_push("wr_opb", 8'hA5);
    sb_pop(operand_a);
    sb_pop(operand_b);

    // Bus drive of reg 5, then release in the same cycle
    do_write(3'd5, 8'h3C);
    bus_oe = 1'b1; bus_rd_addr = 3'd5;
    #1;
    sb_push("bus_drive", 8'h3C);
    sb_pop(data_bus);
    bus_rd_addr = 3'd3;
    #1;
    sb_push("bus_drive_r3", 8'hA5);
    sb_pop(data_bus);
    bus_oe = 1'b0; tb_drv = 1'b1; tb_val = 8'h5A;
    #1;
    sb_push("bus_release", 8'h5A);
    sb_pop(data_bus);
    tb_drv = 1'b0;

    // Conflict: drive reg 2 while writing reg 4 -> write suppressed
    do_write(3'd2, 8'h11);
    do_write(3'd4, 8'h77);
    bus_oe = 1'b1; bus_rd_addr = 3'd2; wr_en = 1'b1; wr_addr = 3'd4;
    tick();
    sb_push("conflict_pulse", 8'h01);
    sb_pop({7'h0, bus_conflict});
    tick();
    sb_push("conflict_held", 8'h01);
    sb_pop({7'h0, bus_conflict});
    bus_oe = 1'b0; wr_en = 1'b0;
    rd_addr_a = 3'd4; rd_addr_b = 3'd2;
    tick();
    sb_push("conflict_clear", 8'h00);
    sb_pop({7'h0, bus_conflict});
    sb_push("conflict_r4", 8'h77);
    sb_pop(operand_a);
    sb_push("conflict_r2", 8'h11);
    sb_pop(operand_b);

    // Flags load together with a register write, then hold
    zf = 1'b1; pf = 1'b1; cf = 1'b0; vf = 1'b1; flags_we = 1'b1;
    do_write(3'd6, 8'hC3);
    flags_we = 1'b0;
    sb_push("flags_load", 8'h0B);
    sb_pop({4'h0, flags});
    zf = 1'b0; pf = 1'b0; cf = 1'b1; vf = 1'b0;
    tick();
    sb_push("flags_hold", 8'h0B);
    sb_pop({4'h0, flags});
    flags_we = 1'b1;
    tick();
    flags_we = 1'b0;
    sb_push("flags_reload", 8'h04);
    sb_pop({4'h0, flags});
    rd_addr_a = 3'd6;
    #1;
    sb_push("flags_with_wr", 8'hC3);
    sb_pop(operand_a);

    // Random fill of every register, read back through both ports
    for (int i = 0; i < int'(NREGS); i++) begin
      do_write(AW'(i), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < int'(NREGS); i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(NREGS - 1 - i);
      #1;
      sb_push("fill_opa", model[i]);
      sb_push("fill_opb", model[NREGS - 1 - i]);
      sb_pop(operand_a);
      sb_pop(operand_b);
    end

    // Asynchronous reset between edges clears state immediately
    do_write(3'd1, 8'h7E);
    rd_addr_a = 3'd1;
    #1;
    sb_push("pre_async_r1", 8'h7E);
    sb_pop(operand_a);
    bus_oe = 1'b1; wr_en = 1'b1; wr_addr = 3'd0;
    tick();
    bus_oe = 1'b0; wr_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    sb_push("async_r1", 8'h00);
    sb_pop(operand_a);
    sb_push("async_flags", 8'h00);
    sb_pop({4'h0, flags});
    sb_push("async_conflict", 8'h00);
    sb_pop({7'h0, bus_conflict});
    tick();
    rst_n = 1'b1;
    do_write(3'd1, 8'h42);
    sb_push("post_async_wr", 8'h42);
    sb_pop(operand_a);

    if (exp_q.size() != 0) begin
      check_eq("sb_leftover", 8'(exp_q.size()), 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_file

// File: doc/reg_file.md
# reg_file

General-purpose register file and flags register at the far end of the ALU datapath. It supplies the two ALU operands from combinational read ports and latches results back off the shared tristate data bus. It captures the ALU condition flags on command and can drive any register onto the same bus. It sits between the control unit (addresses and enables) and the ALU (operands, result bus, flags).

## Interface
Parameters:
- DATA_W, 8, register and bus width
- NUM_REGS, 8, register count (power of two, ≥2)
- REG_ADDR_W, $clog2(NUM_REGS), register address width (localparam)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rd_addr_a  input  REG_ADDR_W  operand A read address
- rd_addr_b  input  REG_ADDR_W  operand B read address
- operand_a  output  DATA_W  regs[rd_addr_a], combinational
- operand_b  output  DATA_W  regs[rd_addr_b], combinational
- wr_en  input  1  capture data_bus into regs[wr_addr] at clock edge
- wr_addr  input  REG_ADDR_W  write address
- bus_oe  input  1  drive regs[bus_rd_addr] onto data_bus
- bus_rd_addr  input  REG_ADDR_W  bus-drive address
- data_bus  inout  DATA_W  shared tristate bus; high-Z when bus_oe=0
- flags_we  input  1  capture flag inputs at clock edge
- zero_flag_in, positive_flag_in, carry_flag_in, signed_overflow_in  input  1 each  ALU condition flags
- flags  output  4  registered {signed_overflow, carry, positive, zero}
- bus_conflict  output  1  registered one-cycle pulse: wr_en and bus_oe were both high

## Operation
- Reads: operand_a/operand_b are pure mux outputs of current register state; no bypass. A read of the address being written in the same cycle returns the old value until after the edge.
- Write: on a rising edge with wr_en=1 and bus_oe=0, regs[wr_addr] <= data_bus.
- Bus drive: bus_oe=1 drives regs[bus_rd_addr] combinationally; otherwise data_bus is 'z on all bits.
- Conflict: wr_en=1 and bus_oe=1 in the same cycle suppresses the write (no register changes). bus_conflict=1 for the following cycle only. Consecutive conflicting cycles keep it high.
- Flags: flags_we=1 loads all four flag bits together; otherwise they hold. flags_we is independent of wr_en and bus_oe; both may act in one cycle.
- All registers are writable; no hardwired register.
- Out-of-range addresses are not possible (NUM_REGS is a power of two).

## Timing
- Reset (rst_n=0, asynchronous): all regs = 0, flags = 4'b0000, bus_conflict = 0. Bus drive is purely combinational from bus_oe, so data_bus may be driven (with 0) during reset only if bus_oe=1.
- Reset deassertion is sampled at clk; the first write can occur on the first edge with rst_n=1.
- Reset mid-write: the asynchronous reset wins, and the register reads 0 afterward.
- Write latency: 1 cycle (value visible on operand_* and bus drive after the edge).
- Flag latency: 1 cycle.
- Read and bus-drive latency: 0 cycles (combinational).
- Bus-drive enable and disable are combinational: high-Z takes effect in the same cycle bus_oe falls.

## Structure
- Add to alu_pkg:
  - flag bit index constants FLAG_Z=0, FLAG_P=1, FLAG_C=2, FLAG_V=3
  - packed typedef flags_t {v, c, p, z}
  - localparam FLAGS_W=4
- flags is typed flags_t internally and exported as 4 bits.
- One sub-module is natural: flag_reg, a 4-bit enable register with asynchronous active-low reset. It is instantiated once.
- Register storage is an unpacked array of DATA_W vectors inside reg_file.

## Test plan
- Reset: hold rst_n=0 with wr_en=1 and the bus at 8'hFF → all operand reads 0, flags=0000, bus_conflict=0. After release, read all 8 addresses → 0.
- Write/read: drive bus 8'hA5, wr_en=1, wr_addr=3 → operand_a with rd_addr_a=3 reads 8'hA5 after the edge and old value 0 in the same cycle. rd_addr_b=3 also reads A5.
- Bus drive: regs[5]=8'h3C, bus_oe=1, bus_rd_addr=5 → data_bus=8'h3C. bus_oe=0 → data_bus=8'hzz same cycle.
- Conflict: regs[2]=8'h11, bus_oe=1 (addr 2), wr_en=1, wr_addr=4 → regs[4] unchanged. bus_conflict=1 for exactly one cycle, then 0.
- Flags: flags_we=1 with z=1, p=1, c=0, v=1 → flags=4'b1011 next cycle. Change the inputs with flags_we=0 → flags hold 1011.
- Async reset mid-operation: assert rst_n=0 between edges after a write of 8'h7E to reg 1 → operand reads 0 immediately, without waiting for a clock edge.
